// File: rtl/cpcs_enc_8b10b.sv
// rtl/cpcs_enc_8b10b.sv - transmit 8B/10B encoder with running disparity and K28.5 idle insertion (optional CPCS_ENC_KERR_CNT_EN adds kerr_cnt)
module cpcs_enc_8b10b #(
  parameter bit IDLE_INSERT = 1'b1
) (
  input  logic       tbc,
  input  logic       aresetn,
  input  logic       ce,
  input  logic [7:0] tx_data,
  input  logic       tx_k,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [9:0] tx_code,
  output logic       tx_code_vld,
  output logic       rd_out,
  output logic       tx_kerr
`ifdef CPCS_ENC_KERR_CNT_EN
  ,
  output logic [7:0] kerr_cnt
`endif
);

  logic [7:0] enc_byte;
  logic       enc_k;
  logic       k_legal;
  logic       kerr_now;
  logic [4:0] x;
  logic [2:0] y;
  logic [5:0] c6_neg;
  logic [5:0] c6;
  logic [3:0] c4_neg;
  logic [3:0] c4;
  logic       unbal6;
  logic       unbal4;
  logic       rd6;
  logic       alt7;
  logic       rd_next;
  logic [9:0] code_next;

  assign tx_ready = ce;

  // Legal control characters: every K28.y plus K23.7, K27.7, K29.7, K30.7
  always_comb begin
    k_legal  = (tx_data[4:0] == 5'd28) ||
               ((tx_data[7:5] == 3'd7) &&
                ((tx_data[4:0] == 5'd23) || (tx_data[4:0] == 5'd27) ||
                 (tx_data[4:0] == 5'd29) || (tx_data[4:0] == 5'd30)));
    kerr_now = tx_valid & tx_k & ~k_legal;
  end

  // Encode the offered byte, or K28.5 when idle, against the current RD
  always_comb begin
    enc_byte = tx_valid ? tx_data : 8'hBC;
    enc_k    = tx_valid ? (tx_k & k_legal) : 1'b1;
    x        = enc_byte[4:0];
    y        = enc_byte[7:5];
    // RD- column of the 5b/6b table, written abcdei with a at the MSB
    case (x)
      5'd0:  c6_neg = 6'b100111;
      5'd1:  c6_neg = 6'b011101;
      5'd2:  c6_neg = 6'b101101;
      5'd3:  c6_neg = 6'b110001;
      5'd4:  c6_neg = 6'b110101;
      5'd5:  c6_neg = 6'b101001;
      5'd6:  c6_neg = 6'b011001;
      5'd7:  c6_neg = 6'b111000;
      5'd8:  c6_neg = 6'b111001;
      5'd9:  c6_neg = 6'b100101;
      5'd10: c6_neg = 6'b010101;
      5'd11: c6_neg = 6'b110100;
      5'd12: c6_neg = 6'b001101;
      5'd13: c6_neg = 6'b101100;
      5'd14: c6_neg = 6'b011100;
      5'd15: c6_neg = 6'b010111;
      5'd16: c6_neg = 6'b011011;
      5'd17: c6_neg = 6'b100011;
      5'd18: c6_neg = 6'b010011;
      5'd19: c6_neg = 6'b110010;
      5'd20: c6_neg = 6'b001011;
      5'd21: c6_neg = 6'b101010;
      5'd22: c6_neg = 6'b011010;
      5'd23: c6_neg = 6'b111010;
      5'd24: c6_neg = 6'b110011;
      5'd25: c6_neg = 6'b100110;
      5'd26: c6_neg = 6'b010110;
      5'd27: c6_neg = 6'b110110;
      5'd28: c6_neg = 6'b001110;
      5'd29: c6_neg = 6'b101110;
      5'd30: c6_neg = 6'b011110;
      default: c6_neg = 6'b101011;
    endcase
    if (enc_k && (x == 5'd28)) begin
      c6_neg = 6'b001111;
    end
    unbal6 = ($countones(c6_neg) != 3);
    // D.07 is balanced but still has two spellings
    c6  = ((unbal6 || (x == 5'd7)) && rd_out) ? ~c6_neg : c6_neg;
    rd6 = rd_out ^ unbal6;

    // Alternate x.A7 avoids a run of five inside the combined code group
    alt7 = enc_k ||
           (!rd6 && ((x == 5'd17) || (x == 5'd18) || (x == 5'd20))) ||
           (rd6 && ((x == 5'd11) || (x == 5'd13) || (x == 5'd14)));
    case (y)
      3'd0:    c4_neg = 4'b1011;
      3'd1:    c4_neg = 4'b1001;
      3'd2:    c4_neg = 4'b0101;
      3'd3:    c4_neg = 4'b1100;
      3'd4:    c4_neg = 4'b1101;
      3'd5:    c4_neg = 4'b1010;
      3'd6:    c4_neg = 4'b0110;
      default: c4_neg = alt7 ? 4'b0111 : 4'b1110;
    endcase
    unbal4 = ($countones(c4_neg) != 2);
    // Balanced K28 3b/4b codes are inverted after a negative 6b sub-block
    if ((unbal4 || (y == 3'd3)) && rd6) begin
      c4 = ~c4_neg;
    end else if (enc_k && !unbal4 && (y != 3'd3) && !rd6) begin
      c4 = ~c4_neg;
    end else begin
      c4 = c4_neg;
    end
    rd_next = rd6 ^ unbal4;

    // Bit 0 carries a, the first bit on the wire
    code_next = {c4[0], c4[1], c4[2], c4[3],
                 c6[0], c6[1], c6[2], c6[3], c6[4], c6[5]};
  end

  // Register the code group, its qualifier, RD and the illegal-K pulse
  always_ff @(posedge tbc or negedge aresetn) begin
    if (!aresetn) begin
      tx_code     <= 10'h000;
      tx_code_vld <= 1'b0;
      rd_out      <= 1'b0;
      tx_kerr     <= 1'b0;
    end else if (ce) begin
      tx_kerr <= kerr_now;
      if (tx_valid) begin
        tx_code     <= code_next;
        tx_code_vld <= 1'b1;
        rd_out      <= rd_next;
      end else begin
        tx_code_vld <= 1'b0;
        if (IDLE_INSERT) begin
          tx_code <= code_next;
          rd_out  <= rd_next;
        end
      end
    end else begin
      tx_kerr <= 1'b0;
    end
  end

`ifdef CPCS_ENC_KERR_CNT_EN
  // Saturating count of illegal-K pulses
  always_ff @(posedge tbc or negedge aresetn) begin
    if (!aresetn) begin
      kerr_cnt <= 8'h00;
    end else if (ce && kerr_now && (kerr_cnt != 8'hFF)) begin
      kerr_cnt <= kerr_cnt + 8'h01;
    end
  end
`endif

endmodule

// File: tb/tb_cpcs_enc_8b10b.sv
// tb/tb_cpcs_enc_8b10b.sv - self-checking bench for cpcs_enc_8b10b (honours CPCS_ENC_KERR_CNT_EN)
module tb_cpcs_enc_8b10b;

  logic       tbc = 1'b0;
  logic       aresetn = 1'b0;
  logic       ce = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_k = 1'b0;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [9:0] tx_code;
  logic       tx_code_vld;
  logic       rd_out;
  logic       tx_kerr;
`ifdef CPCS_ENC_KERR_CNT_EN
  logic [7:0] kerr_cnt;
`endif

  always #5 tbc = ~tbc;

  cpcs_enc_8b10b dut (
    .tbc         (tbc),
    .aresetn     (aresetn),
    .ce          (ce),
    .tx_data     (tx_data),
    .tx_k        (tx_k),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .tx_code     (tx_code),
    .tx_code_vld (tx_code_vld),
    .rd_out      (rd_out),
    .tx_kerr     (tx_kerr)
`ifdef CPCS_ENC_KERR_CNT_EN
    ,
    .kerr_cnt    (kerr_cnt)
`endif
  );

  // Standard tables, RD- column, written abcdei / fghj with a or f at the MSB
  logic [5:0] t6 [32] = '{
    6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001, 6'b011001, 6'b111000,
    6'b111001, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b010111,
    6'b011011, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
    6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110, 6'b011110, 6'b101011};
  logic [3:0] t4 [8] = '{4'b1011, 4'b1001, 4'b0101, 4'b1100, 4'b1101, 4'b1010, 4'b0110, 4'b1110};
  logic [7:0] tk_byte [12] = '{8'h1C, 8'h3C, 8'h5C, 8'h7C, 8'h9C, 8'hBC, 8'hDC, 8'hFC,
                               8'hF7, 8'hFB, 8'hFD, 8'hFE};
  // Complete K code groups for RD-; the RD+ spelling is the bitwise complement
  logic [9:0] tk [12] = '{
    10'b001111_0100, 10'b001111_1001, 10'b001111_0101, 10'b001111_0011,
    10'b001111_0010, 10'b001111_1010, 10'b001111_0110, 10'b001111_1000,
    10'b111010_1000, 10'b110110_1000, 10'b101110_1000, 10'b011110_1000};

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int disp(input logic [9:0] c, input int w);
    return 2 * $countones(c) - w;
  endfunction

  function automatic int rd_after(input int rd, input int d);
    if (d > 0) return 1;
    if (d < 0) return -1;
    return rd;
  endfunction

  // Reference encoder: RD is -1 or +1; every unbalanced sub-block is spelled
  // so that its disparity pulls RD back toward the opposite sign
  function automatic void model(input logic [7:0] d, input logic k, input int rd_in,
                                output logic [9:0] code, output int rd_o, output logic kerr);
    logic [5:0] s6;
    logic [3:0] s4;
    logic [9:0] cat;
    int rd6;
    int x;
    int y;
    bit legal;
    int ki;
    x = int'(d[4:0]);
    y = int'(d[7:5]);
    legal = 1'b0;
    ki = 0;
    for (int i = 0; i < 12; i++) begin
      if (tk_byte[i] == d) begin
        legal = 1'b1;
        ki = i;
      end
    end
    kerr = k && !legal;
    if (k && legal) begin
      cat = (rd_in < 0) ? tk[ki] : ~tk[ki];
      rd_o = rd_after(rd_in, disp(cat, 10));
    end else begin
      s6 = t6[x];
      if (disp({4'b0, s6}, 6) != 0) begin
        if ((disp({4'b0, s6}, 6) > 0) != (rd_in < 0)) s6 = ~s6;
      end else if (x == 7 && rd_in > 0) begin
        s6 = ~s6;
      end
      rd6 = rd_after(rd_in, disp({4'b0, s6}, 6));
      if (y == 7 && ((rd6 < 0 && (x == 17 || x == 18 || x == 20)) ||
                     (rd6 > 0 && (x == 11 || x == 13 || x == 14))))
        s4 = 4'b0111;
      else
        s4 = t4[y];
      if (disp({6'b0, s4}, 4) != 0) begin
        if ((disp({6'b0, s4}, 4) > 0) != (rd6 < 0)) s4 = ~s4;
      end else if (y == 3 && rd6 > 0) begin
        s4 = ~s4;
      end
      rd_o = rd_after(rd6, disp({6'b0, s4}, 4));
      cat = {s6, s4};
    end
    for (int i = 0; i < 10; i++) code[i] = cat[9-i];
  endfunction

  // Expected registered outputs
  int         m_rd = -1;
  int         m_rd_prev = -1;
  logic [9:0] m_code = 10'h000;
  logic       m_vld = 1'b0;
  logic       m_kerr = 1'b0;
  int         m_cnt = 0;
  bit         m_new = 1'b0;
  bit         chk_en = 1'b0;
  logic [9:0] mc;
  int         mr;
  logic       me;

  always @(posedge tbc or negedge aresetn) begin
    if (!aresetn) begin
      m_rd = -1;
      m_code = 10'h000;
      m_vld = 1'b0;
      m_kerr = 1'b0;
      m_cnt = 0;
      m_new = 1'b0;
    end else begin
      m_new = 1'b0;
      if (ce) begin
        m_rd_prev = m_rd;
        if (tx_valid) begin
          model(tx_data, tx_k, m_rd, mc, mr, me);
          m_vld = 1'b1;
          m_kerr = me;
          if (me && m_cnt < 255) m_cnt++;
        end else begin
          model(8'hBC, 1'b1, m_rd, mc, mr, me);
          m_vld = 1'b0;
          m_kerr = 1'b0;
        end
        m_code = mc;
        m_rd = mr;
        m_new = 1'b1;
      end else begin
        m_kerr = 1'b0;
      end
    end
  end

  // Per-cycle comparison against the model plus a disparity sanity check
  int dd;
  always @(negedge tbc) begin
    if (chk_en) begin
      chk("code", 32'(tx_code), 32'(m_code));
      chk("code_vld", 32'(tx_code_vld), 32'(m_vld));
      chk("rd_out", 32'(rd_out), 32'(m_rd > 0));
      chk("kerr", 32'(tx_kerr), 32'(m_kerr));
      chk("ready", 32'(tx_ready), 32'(ce));
`ifdef CPCS_ENC_KERR_CNT_EN
      chk("kerr_cnt", 32'(kerr_cnt), 32'(m_cnt));
`endif
      if (m_new && aresetn) begin
        dd = disp(tx_code, 10);
        chk("disp_bound", 32'(dd == -2 || dd == 0 || dd == 2), 32'd1);
        chk("rd_track", 32'(rd_out), 32'(rd_after(m_rd_prev, dd) > 0));
      end
    end
  end

  task automatic drive(input logic v, input logic k, input logic [7:0] d, input logic c);
    @(negedge tbc);
    #1;
    tx_valid = v;
    tx_k = k;
    tx_data = d;
    ce = c;
  endtask

  task automatic lit(input string nm, input logic [9:0] code, input logic vld, input logic rd);
    @(posedge tbc);
    #2;
    chk({nm, "_code"}, 32'(tx_code), 32'(code));
    chk({nm, "_vld"}, 32'(tx_code_vld), 32'(vld));
    chk({nm, "_rd"}, 32'(rd_out), 32'(rd));
  endtask

  task automatic do_reset();
    @(negedge tbc);
    #1;
    aresetn = 1'b0;
    ce = 1'b0;
    tx_valid = 1'b0;
    @(negedge tbc);
    #1;
    aresetn = 1'b1;
  endtask

  logic [7:0] stream [16] = '{8'h00, 8'hEB, 8'h07, 8'h63, 8'hF1, 8'hF2, 8'hF4, 8'h4B,
                              8'h2D, 8'hAE, 8'h1F, 8'hFF, 8'h5C, 8'h83, 8'hC7, 8'h95};
  logic [9:0] pc;
  int         pr;
  logic       pe;
  logic [7:0] rb;
  logic       rk;

  initial begin
    // Pin the reference model to hand-derived code groups
    model(8'h00, 1'b0, -1, pc, pr, pe);
    chk("pin_d0.0", 32'(pc), 32'h0B9);
    model(8'hBC, 1'b1, -1, pc, pr, pe);
    chk("pin_k28.5n", 32'(pc), 32'h17C);
    chk("pin_k28.5n_rd", 32'(pr), 32'd1);
    model(8'hBC, 1'b1, 1, pc, pr, pe);
    chk("pin_k28.5p", 32'(pc), 32'h283);
    model(8'hEB, 1'b0, -1, pc, pr, pe);
    chk("pin_d11.7n", 32'(pc), 32'h1CB);
    model(8'hEB, 1'b0, 1, pc, pr, pe);
    chk("pin_d11.7p", 32'(pc), 32'h04B);
    chk("pin_d11.7p_rd", 32'(pr), 32'hFFFF_FFFF);

    // Reset values
    repeat (3) @(negedge tbc);
    #1;
    chk("rst_code", 32'(tx_code), 32'h000);
    chk("rst_vld", 32'(tx_code_vld), 32'd0);
    chk("rst_rd", 32'(rd_out), 32'd0);
    chk("rst_kerr", 32'(tx_kerr), 32'd0);
`ifdef CPCS_ENC_KERR_CNT_EN
    chk("rst_cnt", 32'(kerr_cnt), 32'd0);
`endif
    chk_en = 1'b1;
    aresetn = 1'b1;

    // First byte after reset: D.0.0
    drive(1'b1, 1'b0, 8'h00, 1'b1);
    lit("d0.0", 10'h0B9, 1'b1, 1'b0);

    // Two idle cycles after reset
    do_reset();
    drive(1'b0, 1'b0, 8'h00, 1'b1);
    lit("idle1", 10'h17C, 1'b0, 1'b1);
    lit("idle2", 10'h283, 1'b0, 1'b0);

    // Illegal K encodes as data and flags kerr
    drive(1'b1, 1'b1, 8'h00, 1'b1);
    lit("badk", 10'h0B9, 1'b1, 1'b0);
    chk("badk_kerr", 32'(tx_kerr), 32'd1);

    // D.11.7 from RD- then RD+
    drive(1'b1, 1'b0, 8'hEB, 1'b1);
    lit("d11.7n", 10'h1CB, 1'b1, 1'b1);
    chk("d11.7n_kerr", 32'(tx_kerr), 32'd0);
    drive(1'b1, 1'b0, 8'hEB, 1'b1);
    lit("d11.7p", 10'h04B, 1'b1, 1'b0);

    // 16-byte stream with ce toggling; offered bytes during ce=0 are ignored
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b0, stream[i], 1'b1);
      drive(1'b1, 1'b1, ~stream[i], 1'b0);
    end

    // Reset mid-stream while RD+
    do_reset();
    drive(1'b0, 1'b0, 8'h00, 1'b1);
    lit("pre_rst", 10'h17C, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 8'h55, 1'b1);
    #2;
    aresetn = 1'b0;
    #1;
    chk("midrst_code", 32'(tx_code), 32'h000);
    chk("midrst_vld", 32'(tx_code_vld), 32'd0);
    chk("midrst_rd", 32'(rd_out), 32'd0);
    @(negedge tbc);
    #1;
    aresetn = 1'b1;
    tx_valid = 1'b1;
    tx_k = 1'b0;
    tx_data = 8'h00;
    lit("post_rst", 10'h0B9, 1'b1, 1'b0);

    // 300 illegal K bytes
    for (int i = 0; i < 300; i++) drive(1'b1, 1'b1, 8'h00, 1'b1);
    @(posedge tbc);
    #2;
    chk("kerr_last", 32'(tx_kerr), 32'd1);
`ifdef CPCS_ENC_KERR_CNT_EN
    chk("kerr_cnt_sat", 32'(kerr_cnt), 32'hFF);
`endif

    // Random traffic: data, legal K, illegal K, idles and ce gaps
    for (int i = 0; i < 3000; i++) begin
      rb = 8'($urandom_range(0, 255));
      rk = 1'b0;
      case ($urandom_range(0, 9))
        0: begin rk = 1'b1; rb = tk_byte[$urandom_range(0, 11)]; end
        1: rk = 1'b1;
        default: rk = 1'b0;
      endcase
      drive(1'($urandom_range(0, 3) != 0), rk, rb, 1'($urandom_range(0, 7) != 0));
    end

    drive(1'b0, 1'b0, 8'h00, 1'b1);
    @(negedge tbc);
    @(negedge tbc);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
